// File: rtl/xls_add_tree_pipe.sv
// Pipelined unsigned adder tree: NUM_IN operands reduced pairwise through registered levels,
// with valid/ready flow control, optional saturation and an overflow flag.
module xls_add_tree_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_IN   = 3,
  parameter int unsigned SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned Levels = $clog2(NUM_IN);
  // Even lane count so the pair index 2j+1 never leaves the array.
  localparam int unsigned Lanes  = 2 * ((NUM_IN + 1) / 2);

  // Number of live operands held by stage lvl.
  function automatic int unsigned lane_cnt(input int unsigned lvl);
    return (NUM_IN + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  logic [Levels:0]  v_q, v_d, adv;
  logic [WIDTH-1:0] dat_q  [Levels+1][Lanes];
  logic             ovf_q  [Levels+1][Lanes];
  logic [WIDTH-1:0] nd_dat [Levels+1][Lanes];
  logic             nd_ovf [Levels+1][Lanes];

  // A stage can load if it, or any stage after it, is empty, or the output is popped.
  always_comb begin
    logic acc;
    acc = out_ready;
    adv = '0;
    for (int s = int'(Levels); s >= 0; s--) begin
      acc    = acc | ~v_q[s];
      adv[s] = acc;
    end
  end

  assign in_ready = adv[0];

  always_comb begin
    v_d    = v_q;
    v_d[0] = adv[0] ? in_valid : v_q[0];
    for (int s = 1; s <= int'(Levels); s++) begin
      if (adv[s]) begin
        v_d[s] = v_q[s-1];
      end
    end
  end

  always_comb begin
    logic [WIDTH:0] sum;
    sum = '0;
    for (int s = 0; s <= int'(Levels); s++) begin
      for (int j = 0; j < int'(Lanes); j++) begin
        nd_dat[s][j] = '0;
        nd_ovf[s][j] = 1'b0;
      end
    end
    for (int i = 0; i < int'(NUM_IN); i++) begin
      nd_dat[0][i] = in_data[i*WIDTH +: WIDTH];
    end
    for (int k = 1; k <= int'(Levels); k++) begin
      for (int j = 0; j < int'(Lanes / 2); j++) begin
        if (32'(2 * j + 1) < lane_cnt(32'(k - 1))) begin
          sum          = {1'b0, dat_q[k-1][2*j]} + {1'b0, dat_q[k-1][2*j+1]};
          nd_dat[k][j] = ((SATURATE != 0) && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
          nd_ovf[k][j] = ovf_q[k-1][2*j] | ovf_q[k-1][2*j+1] | sum[WIDTH];
        end else if (32'(2 * j) < lane_cnt(32'(k - 1))) begin
          // Odd last operand rides through unchanged.
          nd_dat[k][j] = dat_q[k-1][2*j];
          nd_ovf[k][j] = ovf_q[k-1][2*j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s <= int'(Levels); s++) begin
        for (int j = 0; j < int'(Lanes); j++) begin
          dat_q[s][j] <= '0;
          ovf_q[s][j] <= 1'b0;
        end
      end
    end else begin
      v_q <= v_d;
      if (in_valid && adv[0]) begin
        for (int j = 0; j < int'(Lanes); j++) begin
          dat_q[0][j] <= nd_dat[0][j];
          ovf_q[0][j] <= nd_ovf[0][j];
        end
      end
      for (int s = 1; s <= int'(Levels); s++) begin
        if (adv[s] && v_q[s-1]) begin
          for (int j = 0; j < int'(Lanes); j++) begin
            dat_q[s][j] <= nd_dat[s][j];
            ovf_q[s][j] <= nd_ovf[s][j];
          end
        end
      end
    end
  end

  assign out_valid = v_q[Levels];
  assign out_data  = dat_q[Levels][0];
  assign out_ovf   = ovf_q[Levels][0];

endmodule

// File: doc/xls_add_tree_pipe.md
# xls_add_tree_pipe

Parametrised pipelined unsigned adder tree. It sums NUM_IN operands of WIDTH bits through a registered binary reduction tree with valid/ready flow control. It supports wrap-around or saturating arithmetic and reports overflow. It is the generalised successor of the fixed three-input, free-running XLS adder pipeline and is used wherever the datapath needs a multi-operand sum with backpressure.

## Interface
- WIDTH, 32, operand and result width in bits (1..64)
- NUM_IN, 3, number of operands (2..8)
- SATURATE, 0, 0 = wrap modulo 2^WIDTH, 1 = clamp to 2^WIDTH-1
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised externally to clk
- in_data  input  NUM_IN*WIDTH  packed operands; operand i = in_data[i*WIDTH +: WIDTH]
- in_valid  input  1  operand set present
- in_ready  output  1  block accepts the operand set this cycle
- out_data  output  WIDTH  sum
- out_ovf  output  1  sum exceeded 2^WIDTH-1 at some tree node (wrapped or clamped)
- out_valid  output  1  out_data/out_ovf valid
- out_ready  input  1  consumer accepts result

## Operation
- Stage 0 registers in_data on a transfer (in_valid && in_ready).
- Tree depth is L = ceil(log2(NUM_IN)). Level k pairs adjacent operands (0+1, 2+3, …). An odd last operand passes unchanged to the next level. Each level is registered.
- Node add: sum computed at WIDTH+1 bits; carry = bit WIDTH.
  - SATURATE=0: the node result is the low WIDTH bits.
  - SATURATE=1: the node result is all-ones if carry=1, else the low WIDTH bits.
- Overflow: each node carries an ovf bit = OR of its children's ovf bits OR its own carry. Leaf ovf = 0. out_ovf = root ovf.
- Each stage s (0..L) has a valid bit v[s] and data/ovf registers.
- Stage s advances when v[s] = 0 or the next stage advances. The stage after L is the output: it advances when out_ready = 1.
- in_ready = stage 0 can load. It is combinational from out_ready through the valid chain; no skid buffer.
- Bubbles collapse: an empty stage accepts new data even while later stages are stalled.
- While a stage is stalled, its contents hold and out_data/out_ovf remain stable while out_valid=1.
- out_valid = v[L]; out_data/out_ovf are driven directly from stage L registers.

## Timing
- Latency is 1+L cycles from the input transfer edge to out_valid, with no stalls. NUM_IN=2 gives 2, 3..4 gives 3, 5..8 gives 4.
- Throughput is one result per cycle when out_ready is held high.
- Capacity is L+1 results in flight. in_ready drops in the same cycle that every stage is full and out_ready=0.
- in_valid with in_ready=0: no transfer. The source holds data; the block does not sample it.
- Simultaneous output pop and input push when full: both occur in that cycle, and occupancy is unchanged.
- Reset (rst_n=0), asynchronous:
  - all v[s]=0, all data and ovf registers = 0;
  - out_valid=0, out_data=0, out_ovf=0;
  - in_ready=1 while in reset as well as after.
- Reset mid-operation discards all in-flight results; no partial output is produced.
- Order is preserved: results emerge in acceptance order.

## Test plan
- Defaults (WIDTH=32, NUM_IN=3, SATURATE=0): operands 1, 2, 3 applied once with out_ready=1. Required: out_valid exactly 3 cycles later, out_data=6, out_ovf=0.
- Wrap: WIDTH=8, NUM_IN=4, operands 0xFF, 0x01, 0x10, 0x00. Required: out_data=0x10, out_ovf=1.
  - Same operands with SATURATE=1. Required: out_data=0xFF, out_ovf=1.
- Back-to-back: stream sets k = 0..99, each operand equal to k, NUM_IN=5, out_ready=1. Required: 100 consecutive results 5k, one per cycle, latency 4, in_ready never 0.
- Backpressure: NUM_IN=4, out_ready=0 while pushing.
  - Required: exactly 3 sets are accepted, then in_ready=0 and out_data holds stable.
  - Random out_ready toggling afterward: every result matches the scoreboard, in order, none duplicated or lost.
- Bubble collapse: push one set, stall out_ready=0 for 5 cycles, then push a second set. Required: the second set is accepted while the first is stalled at the output.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 results in flight. Required:
  - out_valid=0, out_data=0, out_ovf=0 immediately, without waiting for a clock edge;
  - after release, the first new set produces its correct sum with no stale result emitted.
